// File: rtl/pipeline_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_pkg : shared word width, PC step and fetch-state encoding |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package pipeline_pkg;

    localparam int                 WORD_W  = 32;
    localparam logic [WORD_W-1:0]  PC_STEP = 32'd4;
    localparam int                 ENTRY_W = 2 * WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : small fetch buffer with push/pop/flush and count      |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Flush wins over both push and pop issued in the same cycle.
    assign w_do_push = i_push && (r_count != c_full) && !i_flush;
    assign w_do_pop  = i_pop  && (r_count != '0)     && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_unit : single-outstanding instruction fetch + buffer   |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module instr_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] PC_4_out,
    output logic [WORD_W-1:0] instruction_out,
    output logic              valid_out
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [WORD_W-1:0]  r_pc;
    logic [ENTRY_W-1:0] r_hold;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_valid;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    w_state_nxt = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                // A redirect while dropping keeps dropping until the stale ack lands.
                if (imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_req   = (r_state == IDLE) && !redirect && (w_count < c_depth);
        w_push  = (r_state == WAIT) && imem_ack && !redirect;
        w_flush = redirect;
        w_pop   = w_valid && !stall && !redirect;
    end

    // While a request is outstanding r_pc already holds its address + 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (w_req) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_valid) begin
            r_hold <= w_head;
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W),
        .CNT_W  (CNT_W)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({r_pc, imem_rdata}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_valid         = (w_count != '0);
    assign valid_out       = w_valid;
    assign imem_req        = w_req;
    assign imem_addr       = r_pc;
    assign PC_4_out        = w_valid ? w_head[ENTRY_W-1:WORD_W] : r_hold[ENTRY_W-1:WORD_W];
    assign instruction_out = w_valid ? w_head[WORD_W-1:0]       : r_hold[WORD_W-1:0];

endmodule : instr_fetch_unit
`default_nettype wire
